// File: rtl/wbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wbuf_pkg
// Description : Opcode encodings and width helper for the window buffer bank.
// Revision    : 1.0 - initial release
// ============================================================================
package wbuf_pkg;

    localparam logic [2:0] c_OP_NOP       = 3'b000;
    localparam logic [2:0] c_OP_LOAD      = 3'b001;
    localparam logic [2:0] c_OP_PUSH      = 3'b010;
    localparam logic [2:0] c_OP_SHIFT     = 3'b011;
    localparam logic [2:0] c_OP_CLEAR     = 3'b100;
    localparam logic [2:0] c_OP_SHIFT_ALL = 3'b101;

    typedef enum logic [2:0] {
        OP_NOP       = c_OP_NOP,
        OP_LOAD      = c_OP_LOAD,
        OP_PUSH      = c_OP_PUSH,
        OP_SHIFT     = c_OP_SHIFT,
        OP_CLEAR     = c_OP_CLEAR,
        OP_SHIFT_ALL = c_OP_SHIFT_ALL
    } wbuf_op_e;

    // Index width that never collapses to zero bits for a single entry.
    function automatic int wbuf_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wbuf_channel.sv
`default_nettype none
// ============================================================================
// Module      : wbuf_channel
// Description : One channel of the buffer bank: slot array, fill count, flags.
// Revision    : 1.0 - initial release
// ============================================================================
module wbuf_channel #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    parameter int SW     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      push,
    input  logic                      shift,
    input  logic                      clear,
    input  logic [SW-1:0]             slot,
    input  logic [DATA_W-1:0]         data,
    output logic [DEPTH*DATA_W-1:0]   slots,
    output logic [SW:0]               count,
    output logic                      full,
    output logic                      empty
);

    localparam logic [SW:0] c_DEPTH = (SW+1)'(DEPTH);

    logic [DATA_W-1:0] r_slot [DEPTH];
    logic [SW:0]       r_count;

    // Strobes are mutually exclusive by construction in the decoder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
            r_count <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
            r_count <= '0;
        end else if (load) begin
            for (int i = 0; i < DEPTH; i++)
                if (SW'(i) == slot) r_slot[i] <= data;
            if ({1'b0, slot} >= r_count) r_count <= {1'b0, slot} + 1'b1;
        end else if (push) begin
            if (r_count == c_DEPTH) begin
                for (int i = 0; i < DEPTH-1; i++) r_slot[i] <= r_slot[i+1];
                r_slot[DEPTH-1] <= data;
            end else begin
                for (int i = 0; i < DEPTH; i++)
                    if ((SW+1)'(i) == r_count) r_slot[i] <= data;
                r_count <= r_count + 1'b1;
            end
        end else if (shift && (r_count != '0)) begin
            for (int i = 0; i < DEPTH-1; i++) r_slot[i] <= r_slot[i+1];
            r_slot[DEPTH-1] <= '0;
            r_count         <= r_count - 1'b1;
        end
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_pack
        assign slots[s*DATA_W +: DATA_W] = r_slot[s];
    end

    assign count = r_count;
    assign full  = (r_count == c_DEPTH);
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/wbuffer_bank.sv
`default_nettype none
// ============================================================================
// Module      : wbuffer_bank
// Description : Multi-channel sliding weight/window buffer with command decode.
//               Define WBUF_ERR_EN to add illegal-command detection and `err`.
// Revision    : 1.0 - initial release
// ============================================================================
module wbuffer_bank
    import wbuf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    parameter int NCH    = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic [2:0]                              cmd_op,
    input  logic [wbuf_idx_w(NCH)-1:0]              cmd_ch,
    input  logic [wbuf_idx_w(DEPTH)-1:0]            cmd_slot,
    input  logic [NCH*DATA_W-1:0]                   ch_data,
    output logic [NCH*DEPTH*DATA_W-1:0]             win_data,
    output logic [NCH*(wbuf_idx_w(DEPTH)+1)-1:0]    ch_count,
    output logic [NCH-1:0]                          ch_full,
    output logic [NCH-1:0]                          ch_empty
`ifdef WBUF_ERR_EN
    ,
    output logic                                    err
`endif
);

    localparam int CW = wbuf_idx_w(NCH);
    localparam int SW = wbuf_idx_w(DEPTH);

    logic r_ready;
    logic w_fire;
    logic w_ch_ok;
    logic w_slot_ok;
    logic w_do_load, w_do_push, w_do_shift, w_do_clear, w_do_shift_all;

    assign w_fire    = cmd_valid & r_ready;
    assign w_ch_ok   = (32'(cmd_ch) < NCH);
    assign w_slot_ok = (32'(cmd_slot) < DEPTH);

    always_comb begin
        w_do_load      = 1'b0;
        w_do_push      = 1'b0;
        w_do_shift     = 1'b0;
        w_do_clear     = 1'b0;
        w_do_shift_all = 1'b0;
        case (cmd_op)
            c_OP_LOAD:      w_do_load      = w_ch_ok & w_slot_ok;
            c_OP_PUSH:      w_do_push      = w_ch_ok;
            c_OP_SHIFT:     w_do_shift     = w_ch_ok;
            c_OP_CLEAR:     w_do_clear     = w_ch_ok;
            c_OP_SHIFT_ALL: w_do_shift_all = 1'b1;
            default:        ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ready <= 1'b0;
        else     r_ready <= 1'b1;
    end

    assign cmd_ready = r_ready;

`ifdef WBUF_ERR_EN
    logic w_illegal;
    logic r_err;

    // SHIFT_ALL ignores cmd_ch, so only the channel-addressed opcodes check it.
    assign w_illegal = (cmd_op > c_OP_SHIFT_ALL)
                     | ((cmd_op != c_OP_SHIFT_ALL) & ~w_ch_ok)
                     | ((cmd_op == c_OP_LOAD) & ~w_slot_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= w_fire & w_illegal;
    end

    assign err = r_err;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic w_sel;
        assign w_sel = w_fire & (cmd_ch == CW'(c));

        wbuf_channel #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .SW     (SW)
        ) u_channel (
            .clk   (clk),
            .rst   (rst),
            .load  (w_sel & w_do_load),
            .push  (w_sel & w_do_push),
            .shift ((w_sel & w_do_shift) | (w_fire & w_do_shift_all)),
            .clear (w_sel & w_do_clear),
            .slot  (cmd_slot),
            .data  (ch_data[c*DATA_W +: DATA_W]),
            .slots (win_data[c*DEPTH*DATA_W +: DEPTH*DATA_W]),
            .count (ch_count[c*(SW+1) +: SW+1]),
            .full  (ch_full[c]),
            .empty (ch_empty[c])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_wbuffer_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_wbuffer_bank
// Description : Self-checking bench for wbuffer_bank against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wbuffer_bank;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;
    localparam int NCH    = 3;
    localparam int CW     = 2;
    localparam int SW     = 1;

    logic                          clk       = 1'b0;
    logic                          rst       = 1'b1;
    logic                          cmd_valid = 1'b0;
    logic                          cmd_ready;
    logic [2:0]                    cmd_op    = '0;
    logic [CW-1:0]                 cmd_ch    = '0;
    logic [SW-1:0]                 cmd_slot  = '0;
    logic [NCH*DATA_W-1:0]         ch_data   = '0;
    logic [NCH*DEPTH*DATA_W-1:0]   win_data;
    logic [NCH*(SW+1)-1:0]         ch_count;
    logic [NCH-1:0]                ch_full;
    logic [NCH-1:0]                ch_empty;
`ifdef WBUF_ERR_EN
    logic                          err;
`endif

    wbuffer_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NCH    (NCH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ch    (cmd_ch),
        .cmd_slot  (cmd_slot),
        .ch_data   (ch_data),
        .win_data  (win_data),
        .ch_count  (ch_count),
        .ch_full   (ch_full),
        .ch_empty  (ch_empty)
`ifdef WBUF_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: plain per-channel arrays of slot values and fill counts.
    int m_slot [NCH][DEPTH];
    int m_cnt  [NCH];
    bit m_ready;
    bit m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0;
            for (int s = 0; s < DEPTH; s++) m_slot[c][s] = 0;
        end
        m_ready = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_shift(input int c);
        if (m_cnt[c] > 0) begin
            for (int i = 0; i < DEPTH-1; i++) m_slot[c][i] = m_slot[c][i+1];
            m_slot[c][DEPTH-1] = 0;
            m_cnt[c]--;
        end
    endtask

    task automatic model_apply(input bit v, input int op, input int ch, input int sl, input int d);
        bit ill;
        m_err = 1'b0;
        if (v && m_ready) begin
            ill = (op > 5) || (op != 5 && ch >= NCH) || (op == 1 && sl >= DEPTH);
            if (ill) m_err = 1'b1;
            else case (op)
                1: begin
                    m_slot[ch][sl] = d;
                    if (m_cnt[ch] < sl + 1) m_cnt[ch] = sl + 1;
                end
                2: begin
                    if (m_cnt[ch] < DEPTH) begin
                        m_slot[ch][m_cnt[ch]] = d;
                        m_cnt[ch]++;
                    end else begin
                        for (int i = 0; i < DEPTH-1; i++) m_slot[ch][i] = m_slot[ch][i+1];
                        m_slot[ch][DEPTH-1] = d;
                    end
                end
                3: model_shift(ch);
                4: begin
                    for (int s = 0; s < DEPTH; s++) m_slot[ch][s] = 0;
                    m_cnt[ch] = 0;
                end
                5: for (int c = 0; c < NCH; c++) model_shift(c);
                default: ;
            endcase
        end
        m_ready = 1'b1;
    endtask

    task automatic check_all();
        logic [NCH*DEPTH*DATA_W-1:0] ew;
        logic [NCH*(SW+1)-1:0]       ec;
        logic [NCH-1:0]              ef, ee;
        for (int c = 0; c < NCH; c++) begin
            for (int s = 0; s < DEPTH; s++) ew[(c*DEPTH+s)*DATA_W +: DATA_W] = 8'(m_slot[c][s]);
            ec[c*(SW+1) +: SW+1] = 2'(m_cnt[c]);
            ef[c] = (m_cnt[c] == DEPTH);
            ee[c] = (m_cnt[c] == 0);
        end
        chk("win_data", win_data, ew);
        chk("ch_count", ch_count, ec);
        chk("ch_full", ch_full, ef);
        chk("ch_empty", ch_empty, ee);
        chk("cmd_ready", cmd_ready, m_ready);
`ifdef WBUF_ERR_EN
        chk("err", err, m_err);
`endif
    endtask

    task automatic do_cmd(input bit v, input int op, input int ch, input int sl, input int d);
        cmd_valid = v;
        cmd_op    = 3'(op);
        cmd_ch    = CW'(ch);
        cmd_slot  = SW'(sl);
        ch_data   = (NCH*DATA_W)'($urandom);
        if (ch < NCH) ch_data[ch*DATA_W +: DATA_W] = 8'(d);
        @(posedge clk);
        model_apply(v, op, ch, sl, d);
        #1;
        check_all();
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("midrst_win", win_data, '0);
        chk("midrst_empty", ch_empty, 3'b111);
        chk("midrst_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_ready_low", cmd_ready, 1'b0);
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        chk("rst_empty", ch_empty, 3'b111);
        chk("rst_ready", cmd_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_apply(1'b0, 0, 0, 0, 0);
        #1;
        check_all();
        chk("ready_after_release", cmd_ready, 1'b1);

        // LOAD ch0 slot1
        do_cmd(1, 1, 0, 1, 8'hA5);
        chk("load_ch0", win_data[15:0], 16'hA500);
        chk("load_cnt0", ch_count[1:0], 2'd2);
        chk("load_full0", ch_full[0], 1'b1);
        chk("load_ch1_same", win_data[31:16], 16'h0000);

        // PUSH sliding window on ch1
        do_cmd(1, 2, 1, 0, 8'h11);
        do_cmd(1, 2, 1, 0, 8'h22);
        do_cmd(1, 2, 1, 0, 8'h33);
        chk("push_window", win_data[31:16], 16'h3322);
        chk("push_cnt1", ch_count[3:2], 2'd2);

        // SHIFT_ALL from ch0={02,01}, ch1={04,03}
        do_cmd(1, 4, 0, 0, 0);
        do_cmd(1, 2, 0, 0, 8'h01);
        do_cmd(1, 2, 0, 0, 8'h02);
        do_cmd(1, 4, 1, 0, 0);
        do_cmd(1, 2, 1, 0, 8'h03);
        do_cmd(1, 2, 1, 0, 8'h04);
        do_cmd(1, 5, 3, 0, 0);
        chk("shall_win", win_data[31:0], 32'h0004_0002);
        chk("shall_cnt", ch_count[3:0], 4'b0101);
        do_cmd(1, 5, 0, 0, 0);
        do_cmd(1, 5, 1, 0, 0);
        chk("shall_sat_cnt", ch_count[3:0], 4'b0000);
        chk("shall_sat_empty", ch_empty[1:0], 2'b11);

        // Illegal commands leave state alone
        do_cmd(1, 2, 0, 0, 8'h5A);
        do_cmd(1, 6, 0, 0, 8'hFF);
`ifdef WBUF_ERR_EN
        chk("err_op6", err, 1'b1);
`endif
        do_cmd(1, 1, 3, 0, 8'hEE);
`ifdef WBUF_ERR_EN
        chk("err_badch", err, 1'b1);
`endif
        do_cmd(1, 0, 0, 0, 0);
`ifdef WBUF_ERR_EN
        chk("err_clears", err, 1'b0);
`endif
        chk("illegal_keep", win_data[7:0], 8'h5A);
        chk("illegal_cnt", ch_count[1:0], 2'd1);

        // valid low: no effect
        do_cmd(0, 2, 0, 0, 8'h77);
        chk("novalid_cnt", ch_count[1:0], 2'd1);

        // Back-to-back CLEAR then PUSH on ch2
        do_cmd(1, 2, 2, 0, 8'h99);
        do_cmd(1, 2, 2, 0, 8'h98);
        do_cmd(1, 4, 2, 0, 0);
        do_cmd(1, 2, 2, 0, 8'h7F);
        chk("b2b_win", win_data[47:32], 16'h007F);
        chk("b2b_cnt", ch_count[5:4], 2'd1);

        for (int i = 0; i < 600; i++) begin
            if (i == 300) pulse_reset();
            do_cmd($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 255));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wbuffer_bank.md
# wbuffer_bank

Parametrised multi-channel weight/window buffer; successor to the fixed four-register weight buffer. Holds `NCH` independent channels of `DEPTH` slots of `DATA_W` bits each. Commands arrive from the control unit over a valid/ready interface and can load a slot directly, append into a sliding window, shift, or clear. Sits between the SRAM/SDRAM read paths and the MAC datapath, which reads every slot in parallel.

## Interface
Parameters:
- `DATA_W`, default 8: bits per slot.
- `DEPTH`, default 2: slots per channel, ≥2.
- `NCH`, default 2: channel count, ≥1. Channel c takes data from `ch_data[c]`.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted this cycle when high together with `cmd_valid`.
- `cmd_op`  in  3  opcode, see Operation.
- `cmd_ch`  in  CW = max(1, $clog2(NCH))  target channel.
- `cmd_slot`  in  SW = max(1, $clog2(DEPTH))  target slot, LOAD only.
- `ch_data`  in  NCH*DATA_W  per-channel write data. Channel c occupies `[c*DATA_W +: DATA_W]`.
- `win_data`  out  NCH*DEPTH*DATA_W  all slots. Slot s of channel c occupies `[(c*DEPTH+s)*DATA_W +: DATA_W]`.
- `ch_count`  out  NCH*(SW+1)  fill count per channel, range 0..DEPTH.
- `ch_full`  out  NCH  count == DEPTH.
- `ch_empty`  out  NCH  count == 0.
- `err`  out  1  one-cycle pulse on an illegal command. Only present with `WBUF_ERR_EN`.

## Operation
Opcodes apply on a handshake (`cmd_valid & cmd_ready`). With no handshake, all state holds.
- 000 NOP: no change.
- 001 LOAD: slot `cmd_slot` ← `ch_data[cmd_ch]`. count ← max(count, cmd_slot+1).
- 010 PUSH (sliding window):
  - Not full: slot[count] ← data; count+1.
  - Full: slot[i] ← slot[i+1] for i<DEPTH-1; slot[DEPTH-1] ← data; count stays DEPTH. The oldest value is discarded.
- 011 SHIFT: slot[i] ← slot[i+1]; slot[DEPTH-1] ← 0; count ← count-1, saturating at 0. On an empty channel it is a no-op.
- 100 CLEAR: all slots of `cmd_ch` ← 0; count ← 0.
- 101 SHIFT_ALL: SHIFT applied to every channel simultaneously; `cmd_ch` is ignored.
- 110, 111, or `cmd_ch` ≥ NCH, or LOAD with `cmd_slot` ≥ DEPTH: illegal. No state change; `err` pulses if compiled in.
- Shifts always use current register values, never next-state values. A shift moves exactly one slot per command.
- Only the targeted channel changes, except for SHIFT_ALL.

## Timing
- Reset (asserted, asynchronous): all slots 0, all counts 0, `ch_empty` all 1, `ch_full` all 0, `err` 0, `cmd_ready` 0.
- `cmd_ready` rises on the first clock edge after `rst` deasserts. It then stays 1; the block never stalls.
- Latency is 1 cycle. A command accepted at edge k is visible on `win_data`, `ch_count`, `ch_full` and `ch_empty` immediately after edge k.
- `err` is registered and high for exactly the cycle after the illegal command's edge.
- All outputs are registered or decoded only from registers. There is no combinational path from the `cmd_*` inputs to any output.
- Back-to-back commands are legal every cycle. They may target the same channel; each one sees the prior command's result.
- Reset asserted mid-stream clears everything immediately. Commands in flight are dropped.

## Configuration
- `WBUF_ERR_EN` defined: illegal-command detection and the `err` port exist.
- `WBUF_ERR_EN` undefined:
  - The `err` port is absent.
  - Illegal commands are still ignored (no state change).
  - The decode logic is reduced to the legal cases only.

## Structure
- Package `wbuf_pkg`:
  - `wbuf_op_e` enum for the opcodes.
  - Localparams for the NOP/LOAD/PUSH/SHIFT/CLEAR/SHIFT_ALL encodings.
  - Helper function for the SW width computation.
- Sub-module `wbuf_channel`:
  - Contents: one channel's slot array, its count register, and the full/empty flags.
  - Inputs: decoded per-channel strobes `load`, `push`, `shift`, `clear`.
  - Instantiated NCH times by a generate loop.
- Top level: command decode, `cmd_ready`, and `err`.

## Test plan
Defaults are `DATA_W=8`, `DEPTH=2`, `NCH=2` unless stated.
- Reset: pulse `rst` mid-operation → all `win_data` 0, counts 0, `ch_empty`=2'b11, `cmd_ready`=0. `cmd_ready`=1 one edge after release.
- LOAD: ch0 slot1 ← 0xA5 → `win_data` ch0 = {0xA5, 0x00}, count0=2, `ch_full[0]`=1. ch1 is unchanged.
- PUSH window (ch1): push 0x11, 0x22, 0x33 → after the 3rd push ch1 = {slot1 0x33, slot0 0x22}, count stays 2.
- SHIFT_ALL: ch0={0x02,0x01}, ch1={0x04,0x03} → ch0={0x00,0x02}, ch1={0x00,0x04}, both counts 1. A second and third SHIFT_ALL reach count 0 and saturate there.
- Illegal commands: opcode 110, then LOAD with `cmd_ch`=2 (`NCH=2`) → no state change. `err` pulses 1 cycle each with `WBUF_ERR_EN`; without it, no change only.
- Back-to-back: CLEAR then PUSH 0x7F on consecutive cycles, same channel → slot0=0x7F, count=1.
